// File: rtl/tpu_cmd_scheduler_pkg.sv
// Shared definitions for the TPU command scheduler: opcodes, widths, FSM states, FIFO entry layout.
package tpu_cmd_scheduler_pkg;

    localparam int unsigned TPU_CMD_W = 48;
    localparam int unsigned ENTRY_W   = TPU_CMD_W + 1;
    localparam int unsigned WDOG_W    = 16;

    localparam logic [7:0] TPU_CLEARSCREEN = 8'h01;
    localparam logic [7:0] TPU_PRINT       = 8'h02;
    localparam logic [7:0] TPU_LOCATE      = 8'h03;
    localparam logic [7:0] TPU_SETATTR     = 8'h04;
    localparam logic [7:0] TPU_SETMASK     = 8'h05;
    localparam logic [7:0] TPU_FILLAREA    = 8'h06;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                 last;
        logic [TPU_CMD_W-1:0] command;
    } fifo_entry_t;

    // One-hot pick among eligible requesters; on contention the one not granted last wins.
    function automatic logic [1:0] rr_pick(input logic elig0, input logic elig1, input logic last_was_1);
        logic [1:0] pick;
        if (elig0 && elig1) begin
            pick = last_was_1 ? 2'b01 : 2'b10;
        end else begin
            pick = {elig1, elig0};
        end
        return pick;
    endfunction

endpackage

// File: rtl/tpu_cmd_scheduler_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; power-of-two depth, wrap-bit pointers.
module tpu_cmd_scheduler_sync_fifo #(
    parameter int unsigned WIDTH = 49,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a full FIFO refuses a push even when popped in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/tpu_cmd_scheduler.sv
// Shares the TPU command port between two requesters: per-requester FIFOs, round-robin with
// atomic sequences (lock until 'last'), issue/busy handshake and a busy watchdog.
module tpu_cmd_scheduler
    import tpu_cmd_scheduler_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [TPU_CMD_W-1:0] req0_command,
    input  logic                 req0_last,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [TPU_CMD_W-1:0] req1_command,
    input  logic                 req1_last,
    output logic                 req1_ready,
    output logic                 tpu_execute,
    output logic [TPU_CMD_W-1:0] tpu_command,
    input  logic                 tpu_busy,
    output logic [1:0]           grant,
    output logic                 idle,
    output logic                 timeout_error
);

    localparam logic [WDOG_W-1:0] TIMEOUT_LIM = WDOG_W'(TIMEOUT_CYCLES);
    localparam logic              WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [WDOG_W-1:0] WDOG_MAX    = '1;

    fifo_entry_t din0, din1, head0, head1, sel_head;
    logic        push0, push1, pop0, pop1;
    logic        full0, full1, empty0, empty1;

    sched_state_e         state_q, state_d;
    logic                 exec_q, exec_d;
    logic [TPU_CMD_W-1:0] cmd_q, cmd_d;
    logic [1:0]           grant_q, grant_d;
    logic                 timeout_q, timeout_d;
    logic                 lock_q, lock_d;
    logic                 rr_last1_q, rr_last1_d;
    logic                 issued_last_q, issued_last_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;

    logic       elig0, elig1, win, wdog_hit;
    logic [1:0] pick;
    logic [WDOG_W-1:0] wdog_inc;

    assign req0_ready = !full0 && !reset;
    assign req1_ready = !full1 && !reset;
    assign push0      = req0_valid && req0_ready;
    assign push1      = req1_valid && req1_ready;
    assign din0       = '{last: req0_last, command: req0_command};
    assign din1       = '{last: req1_last, command: req1_command};

    tpu_cmd_scheduler_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo0 (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push0),
        .pop_i   (pop0),
        .din_i   (din0),
        .dout_o  (head0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    tpu_cmd_scheduler_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push1),
        .pop_i   (pop1),
        .din_i   (din1),
        .dout_o  (head1),
        .full_o  (full1),
        .empty_o (empty1)
    );

    // While locked only the owner may issue; an empty owner FIFO deliberately stalls.
    assign elig0    = !empty0 && (!lock_q || grant_q[0]);
    assign elig1    = !empty1 && (!lock_q || grant_q[1]);
    assign pick     = rr_pick(elig0, elig1, rr_last1_q);
    assign win      = (state_q == ST_IDLE) && !tpu_busy && (pick != 2'b00);
    assign wdog_inc = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_W'(1);
    assign wdog_hit = WDOG_EN && (wdog_inc == TIMEOUT_LIM);

    assign tpu_execute   = exec_q;
    assign tpu_command   = cmd_q;
    assign grant         = grant_q;
    assign timeout_error = timeout_q;
    assign idle          = empty0 && empty1 && (state_q == ST_IDLE) && !lock_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            exec_q        <= 1'b0;
            cmd_q         <= '0;
            grant_q       <= 2'b00;
            timeout_q     <= 1'b0;
            lock_q        <= 1'b0;
            rr_last1_q    <= 1'b1;
            issued_last_q <= 1'b1;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            exec_q        <= exec_d;
            cmd_q         <= cmd_d;
            grant_q       <= grant_d;
            timeout_q     <= timeout_d;
            lock_q        <= lock_d;
            rr_last1_q    <= rr_last1_d;
            issued_last_q <= issued_last_d;
            wdog_q        <= wdog_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (win) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (!tpu_busy || wdog_hit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: issue, completion bookkeeping, watchdog.
    always_comb begin
        exec_d        = 1'b0;
        cmd_d         = cmd_q;
        grant_d       = grant_q;
        timeout_d     = timeout_q;
        lock_d        = lock_q;
        rr_last1_d    = rr_last1_q;
        issued_last_d = issued_last_q;
        wdog_d        = wdog_q;
        pop0          = 1'b0;
        pop1          = 1'b0;
        sel_head      = pick[1] ? head1 : head0;
        unique case (state_q)
            ST_IDLE: begin
                if (win) begin
                    pop0          = pick[0];
                    pop1          = pick[1];
                    cmd_d         = sel_head.command;
                    issued_last_d = sel_head.last;
                    grant_d       = pick;
                    exec_d        = 1'b1;
                end
            end
            ST_ISSUE: begin
                wdog_d = '0;
            end
            ST_WAIT: begin
                if (!tpu_busy) begin
                    lock_d     = !issued_last_q;
                    grant_d    = issued_last_q ? 2'b00 : grant_q;
                    rr_last1_d = grant_q[1];
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_hit) begin
                        timeout_d = 1'b1;
                        lock_d    = 1'b0;
                        grant_d   = 2'b00;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tpu_cmd_scheduler.sv
// Directed bench for tpu_cmd_scheduler with a behavioural TPU busy model.
module tb_tpu_cmd_scheduler;
    import tpu_cmd_scheduler_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_last, req0_ready;
    logic [47:0] req0_command;
    logic        req1_valid, req1_last, req1_ready;
    logic [47:0] req1_command;
    logic        tpu_execute, tpu_busy, idle, timeout_error;
    logic [47:0] tpu_command;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tpu_cmd_scheduler #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_command  (req0_command),
        .req0_last     (req0_last),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_command  (req1_command),
        .req1_last     (req1_last),
        .req1_ready    (req1_ready),
        .tpu_execute   (tpu_execute),
        .tpu_command   (tpu_command),
        .tpu_busy      (tpu_busy),
        .grant         (grant),
        .idle          (idle),
        .timeout_error (timeout_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // TPU model: busy from the cycle after execute for a per-opcode time; 0xFF never busy.
    int busy_cnt = 0;
    bit hang     = 1'b0;
    function automatic int busy_time(input logic [7:0] op);
        case (op)
            TPU_LOCATE: return 2;
            TPU_PRINT:  return 3;
            8'hFF:      return 0;
            default:    return 4;
        endcase
    endfunction
    always @(posedge clk) begin
        if (tpu_execute) busy_cnt <= busy_time(tpu_command[7:0]);
        else if (busy_cnt > 0 && !hang) busy_cnt <= busy_cnt - 1;
    end
    assign tpu_busy = (busy_cnt != 0);

    typedef struct packed {
        logic [31:0] cyc;
        logic [47:0] cmd;
        logic [1:0]  gnt;
    } ev_t;
    ev_t log_q[$];
    always @(negedge clk) if (tpu_execute) log_q.push_back({32'(cyc), tpu_command, grant});

    task automatic drive(input bit v0, input logic [47:0] c0, input bit l0,
                         input bit v1, input logic [47:0] c1, input bit l1);
        req0_valid = v0; req0_command = c0; req0_last = l0;
        req1_valid = v1; req1_command = c1; req1_last = l1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_exec(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (tpu_execute) seen = 1'b1;
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int i = 0; i < budget && log_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_command = '0; req1_command = '0; req0_last = 1'b0; req1_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tpu_execute !== 1'b0) begin failures++; $display("FAIL reset_exec got=%0b exp=0", tpu_execute); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%0b exp=00", grant); end
        checks++; if (tpu_command !== 48'h0) begin failures++; $display("FAIL reset_cmd got=%0h exp=0", tpu_command); end
        checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout_error); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", idle); end
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_reset got=%0b exp=0", req0_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready_after got=%0b exp=11", {req0_ready, req1_ready}); end
    endtask

    task automatic test_single();
        logic [47:0] c;
        bit done;
        c = {24'h0, 8'd5, 8'd3, TPU_LOCATE};
        do_reset();
        drive(1'b1, c, 1'b1, 1'b0, 48'h0, 1'b0);
        checks++; if (tpu_execute !== 1'b0) begin failures++; $display("FAIL single_exec_early got=%0b exp=0", tpu_execute); end
        @(negedge clk);
        checks++; if (tpu_execute !== 1'b1) begin failures++; $display("FAIL single_exec got=%0b exp=1", tpu_execute); end
        checks++; if (tpu_command !== c) begin failures++; $display("FAIL single_cmd got=%0h exp=%0h", tpu_command, c); end
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL single_grant got=%0b exp=01", grant); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0b exp=0", idle); end
        @(negedge clk);
        checks++; if (tpu_execute !== 1'b0) begin failures++; $display("FAIL single_exec_strobe got=%0b exp=0", tpu_execute); end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (idle === 1'b1) done = 1'b1;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_idle_wait got=%0b exp=1", done); end
        checks++; if ({grant, tpu_busy} !== 3'b000) begin failures++; $display("FAIL single_done got=%0b exp=000", {grant, tpu_busy}); end
    endtask

    task automatic test_round_robin();
        int base;
        logic [47:0] c0, c1, exp_c;
        logic [1:0] exp_g;
        int n;
        do_reset();
        base = log_q.size();
        for (int i = 0; i < 3; i++) begin
            c0 = {32'h0, 8'(8'h10 + i), TPU_PRINT};
            c1 = {32'h0, 8'(8'h20 + i), TPU_SETATTR};
            drive(1'b1, c0, 1'b1, 1'b1, c1, 1'b1);
        end
        wait_log(base + 6, 200);
        n = log_q.size() - base;
        checks++; if (n != 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", n); end
        if (n > 6) n = 6;
        for (int k = 0; k < n; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_c = (k % 2 == 0) ? {32'h0, 8'(8'h10 + k / 2), TPU_PRINT}
                                 : {32'h0, 8'(8'h20 + k / 2), TPU_SETATTR};
            checks++; if (log_q[base + k].gnt !== exp_g) begin failures++; $display("FAIL rr_grant[%0d] got=%0b exp=%0b", k, log_q[base + k].gnt, exp_g); end
            checks++; if (log_q[base + k].cmd !== exp_c) begin failures++; $display("FAIL rr_cmd[%0d] got=%0h exp=%0h", k, log_q[base + k].cmd, exp_c); end
            if (k > 0) begin
                checks++;
                if (int'(log_q[base + k].cyc) - int'(log_q[base + k - 1].cyc) < 3) begin
                    failures++;
                    $display("FAIL rr_gap[%0d] got=%0d exp>=3", k, int'(log_q[base + k].cyc) - int'(log_q[base + k - 1].cyc));
                end
            end
        end
    endtask

    task automatic test_lock();
        int base, n;
        logic [47:0] cl, ca, cb;
        logic [47:0] exp_c [3];
        logic [1:0]  exp_g [3];
        cl = {24'h0, 8'd1, 8'd2, TPU_LOCATE};
        ca = {32'h0, 8'h41, TPU_PRINT};
        cb = {32'h0, 8'h42, TPU_PRINT};
        exp_c[0] = cl; exp_c[1] = ca; exp_c[2] = cb;
        exp_g[0] = 2'b10; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        do_reset();
        base = log_q.size();
        drive(1'b0, 48'h0, 1'b0, 1'b1, cl, 1'b0);
        drive(1'b1, cb, 1'b1, 1'b1, ca, 1'b1);
        wait_log(base + 3, 200);
        n = log_q.size() - base;
        checks++; if (n != 3) begin failures++; $display("FAIL lock_count got=%0d exp=3", n); end
        if (n > 3) n = 3;
        for (int k = 0; k < n; k++) begin
            checks++; if (log_q[base + k].gnt !== exp_g[k]) begin failures++; $display("FAIL lock_grant[%0d] got=%0b exp=%0b", k, log_q[base + k].gnt, exp_g[k]); end
            checks++; if (log_q[base + k].cmd !== exp_c[k]) begin failures++; $display("FAIL lock_cmd[%0d] got=%0h exp=%0h", k, log_q[base + k].cmd, exp_c[k]); end
        end
    endtask

    task automatic test_unknown();
        bit seen;
        bit rose;
        int base, gap;
        logic [47:0] cu;
        cu = {40'h0, 8'hFF};
        do_reset();
        drive(1'b1, cu, 1'b1, 1'b0, 48'h0, 1'b0);
        wait_exec(10, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL unk_exec_seen got=%0b exp=1", seen); end
        rose = 1'b0;
        @(negedge clk);
        rose |= tpu_busy;
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL unk_idle_wait got=%0b exp=0", idle); end
        @(negedge clk);
        rose |= tpu_busy;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL unk_idle_back got=%0b exp=1", idle); end
        checks++; if ({rose, timeout_error} !== 2'b00) begin failures++; $display("FAIL unk_busy_timeout got=%0b exp=00", {rose, timeout_error}); end
        base = log_q.size();
        drive(1'b1, cu, 1'b1, 1'b0, 48'h0, 1'b0);
        drive(1'b1, cu, 1'b1, 1'b0, 48'h0, 1'b0);
        wait_log(base + 2, 50);
        checks++;
        if (log_q.size() < base + 2) begin
            failures++; $display("FAIL unk_b2b_count got=%0d exp=2", log_q.size() - base);
        end else begin
            gap = int'(log_q[base + 1].cyc) - int'(log_q[base].cyc);
            if (gap != 3) begin failures++; $display("FAIL unk_b2b_gap got=%0d exp=3", gap); end
        end
    endtask

    task automatic test_watchdog();
        bit seen, extra;
        do_reset();
        hang = 1'b1;
        drive(1'b1, {40'h0, TPU_CLEARSCREEN}, 1'b1, 1'b0, 48'h0, 1'b0);
        wait_exec(10, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL wd_exec_seen got=%0b exp=1", seen); end
        repeat (16) @(negedge clk);
        checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL wd_early got=%0b exp=0", timeout_error); end
        @(negedge clk);
        checks++; if (timeout_error !== 1'b1) begin failures++; $display("FAIL wd_fire got=%0b exp=1", timeout_error); end
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL wd_grant got=%0b exp=00", grant); end
        drive(1'b1, {40'h0, TPU_PRINT}, 1'b1, 1'b0, 48'h0, 1'b0);
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            extra |= tpu_execute;
        end
        checks++; if (extra !== 1'b0) begin failures++; $display("FAIL wd_no_exec_while_busy got=%0b exp=0", extra); end
        hang = 1'b0;
        wait_exec(20, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL wd_resume got=%0b exp=1", seen); end
        checks++; if (timeout_error !== 1'b1) begin failures++; $display("FAIL wd_sticky got=%0b exp=1", timeout_error); end
    endtask

    task automatic test_backpressure_reset();
        bit seen;
        int accepted;
        do_reset();
        hang = 1'b1;
        drive(1'b1, {40'h0, TPU_SETMASK}, 1'b1, 1'b0, 48'h0, 1'b0);
        wait_exec(10, seen);
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL bp_exec_seen got=%0b exp=1", seen); end
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            if (req0_ready === 1'b1) accepted++;
            drive(1'b1, {32'h0, 8'(i), TPU_PRINT}, 1'b1, 1'b0, 48'h0, 1'b0);
        end
        checks++; if (accepted != 8) begin failures++; $display("FAIL bp_accepted got=%0d exp=8", accepted); end
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%0b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", req1_ready); end
        checks++; if ({grant, timeout_error} !== 3'b010) begin failures++; $display("FAIL bp_in_wait got=%0b exp=010", {grant, timeout_error}); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({tpu_execute, grant} !== 3'b000) begin failures++; $display("FAIL bp_rst_out got=%0b exp=000", {tpu_execute, grant}); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL bp_rst_empty got=%0b exp=1", idle); end
        reset = 1'b0;
        hang  = 1'b0;
        @(negedge clk);
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after got=%0b exp=1", req0_ready); end
        repeat (8) @(negedge clk);
        checks++; if (tpu_execute !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL bp_flushed got=%0b exp=01", {tpu_execute, idle}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_unknown();
        test_watchdog();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
